// File: rtl/if_id_queue_pkg.sv
// Shared constants and the entry layout for the IF/ID decoupling queue.
package if_id_queue_pkg;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  // addi x0, x0, 0 -- canonical RISC-V NOP shown to decode when the queue is empty
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam int DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } id_entry_t;

endpackage

// File: rtl/if_id_queue_inst_fifo.sv
// Generic synchronous FIFO with async reset and synchronous clear; caller qualifies push/pop.
module inst_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: FIFO of {pc,inst} with flush, NOP substitution and sticky overflow.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] inst_IF_i,
  input  logic [31:0] pc_IF_i,
  input  logic        push_IF_i,
  output logic        full_IF_o,
  input  logic        stall_ID_i,
  input  logic        flush_i,
  output logic [31:0] inst_ID_o,
  output logic [31:0] pc_ID_o,
  output logic        valid_ID_o,
  output logic        ovf_err_o
);

  // Handshakes: ID takes the head when valid_ID_o & ~stall_ID_i; IF may push when
  // ~full_IF_o, or when full and ID takes the head in the same cycle.
  id_entry_t head;
  id_entry_t wentry;
  logic      empty;
  logic      full;
  logic      pop_req;
  logic      push_req;
  logic      advance;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_clr;
  logic      ovf_set;

  assign valid_ID_o = !empty;
  assign full_IF_o  = full;

  assign pop_req  = valid_ID_o && !stall_ID_i;
  assign push_req = push_IF_i && (!full || pop_req);

  // Flush wins over any same-cycle push or pop; rdy=0 freezes everything.
  assign advance   = rdy && !flush_i;
  assign fifo_push = advance && push_req;
  assign fifo_pop  = advance && pop_req;
  assign fifo_clr  = rdy && flush_i;
  assign ovf_set   = advance && push_IF_i && full && !pop_req;

  assign wentry.pc   = pc_IF_i;
  assign wentry.inst = inst_IF_i;

  inst_fifo #(
    .WIDTH ($bits(id_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .dclk  (dclk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (fifo_clr),
    .wdata (wentry),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign inst_ID_o = valid_ID_o ? head.inst : NOP_INST;
  assign pc_ID_o   = valid_ID_o ? head.pc   : ZERO_WORD;

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      ovf_err_o <= DISABLE;
    end else if (ovf_set) begin
      ovf_err_o <= ENABLE;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        dclk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] inst_IF_i;
  logic [31:0] pc_IF_i;
  logic        push_IF_i;
  logic        full_IF_o;
  logic        stall_ID_i;
  logic        flush_i;
  logic [31:0] inst_ID_o;
  logic [31:0] pc_ID_o;
  logic        valid_ID_o;
  logic        ovf_err_o;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .dclk       (dclk),
    .rst        (rst),
    .rdy        (rdy),
    .inst_IF_i  (inst_IF_i),
    .pc_IF_i    (pc_IF_i),
    .push_IF_i  (push_IF_i),
    .full_IF_o  (full_IF_o),
    .stall_ID_i (stall_ID_i),
    .flush_i    (flush_i),
    .inst_ID_o  (inst_ID_o),
    .pc_ID_o    (pc_ID_o),
    .valid_ID_o (valid_ID_o),
    .ovf_err_o  (ovf_err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 dclk = ~dclk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {pc, inst}, oldest first
  logic        exp_ovf;
  int          n_tests;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : {32'h0, NOP};
    check_eq({tag, ".valid"}, 64'(valid_ID_o), 64'(exp_q.size() != 0));
    check_eq({tag, ".full"},  64'(full_IF_o),  64'(exp_q.size() == DEPTH));
    check_eq({tag, ".inst"},  64'(inst_ID_o),  64'(head[31:0]));
    check_eq({tag, ".pc"},    64'(pc_ID_o),    64'(head[63:32]));
    check_eq({tag, ".ovf"},   64'(ovf_err_o),  64'(exp_ovf));
  endtask

  // Model: flush empties; push while full without a pop is dropped and flagged;
  // otherwise the head leaves if taken and the new entry joins the tail.
  task automatic model_edge(input logic p, input logic [31:0] inst, input logic [31:0] pc,
                            input logic st, input logic fl, input logic r);
    bit have, is_full, take;
    have    = exp_q.size() != 0;
    is_full = exp_q.size() == DEPTH;
    take    = have && !st;
    if (!r) return;
    if (fl) begin
      exp_q.delete();
    end else if (p && is_full && !take) begin
      exp_ovf = 1'b1;
    end else begin
      if (take) void'(exp_q.pop_front());
      if (p) exp_q.push_back({pc, inst});
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, predict, clock once, check at the next negedge.
  task automatic step(input string tag, input logic p, input logic [31:0] inst,
                      input logic [31:0] pc, input logic st, input logic fl, input logic r);
    push_IF_i  = p;
    inst_IF_i  = inst;
    pc_IF_i    = pc;
    stall_ID_i = st;
    flush_i    = fl;
    rdy        = r;
    model_edge(p, inst, pc, st, fl, r);
    @(posedge dclk);
    @(negedge dclk);
    check_outputs(tag);
  endtask

  // Reset pulse between edges, with a push in flight across the preceding edge.
  task automatic pulse_reset(input string tag);
    push_IF_i  = 1'b1;
    inst_IF_i  = $urandom;
    pc_IF_i    = $urandom;
    stall_ID_i = 1'b1;
    flush_i    = 1'b0;
    rdy        = 1'b1;
    @(posedge dclk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check_outputs({tag, ".async"});
    @(negedge dclk);
    rst        = 1'b0;
    push_IF_i  = 1'b0;
    stall_ID_i = 1'b0;
    check_outputs({tag, ".after"});
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; push_IF_i = 1'b0; stall_ID_i = 1'b0; flush_i = 1'b0;
    inst_IF_i = '0; pc_IF_i = '0;
    n_tests = 0; n_fail = 0; exp_ovf = 1'b0;
    @(negedge dclk);

    // 1. reset
    pulse_reset("reset");
    check_eq("reset.inst_nop", 64'(inst_ID_o), 64'(32'h0000_0013));

    // 2. single pass
    step("t2.push", 1, 32'h00500093, 32'h0, 0, 0, 1);
    check_eq("t2.inst_const", 64'(inst_ID_o), 64'(32'h00500093));
    step("t2.drain", 0, 32'h0, 32'h0, 0, 0, 1);
    check_eq("t2.valid_low", 64'(valid_ID_o), 64'(0));

    // 3. fill under stall, then release
    step("t3.pushA", 1, 32'hAAAA0001, 32'h0, 1, 0, 1);
    step("t3.pushB", 1, 32'hBBBB0002, 32'h4, 1, 0, 1);
    check_eq("t3.full", 64'(full_IF_o), 64'(1));
    check_eq("t3.headA", 64'(inst_ID_o), 64'(32'hAAAA0001));

    // 4. full with simultaneous push+pop
    step("t4.pushC", 1, 32'hCCCC0003, 32'h8, 0, 0, 1);
    check_eq("t4.headB", 64'(inst_ID_o), 64'(32'hBBBB0002));
    check_eq("t4.still_full", 64'(full_IF_o), 64'(1));
    step("t4.popB", 0, 32'h0, 32'h0, 0, 0, 1);
    check_eq("t4.headC", 64'(pc_ID_o), 64'(32'h8));
    step("t4.popC", 0, 32'h0, 32'h0, 0, 0, 1);

    // 5. flush with same-cycle push
    step("t5.fill1", 1, 32'h11110001, 32'h10, 1, 0, 1);
    step("t5.fill2", 1, 32'h22220002, 32'h14, 1, 0, 1);
    step("t5.flushD", 1, 32'hDDDD0004, 32'h18, 0, 1, 1);
    check_eq("t5.empty", 64'(valid_ID_o), 64'(0));
    step("t5.pushE", 1, 32'hEEEE0005, 32'h1C, 1, 0, 1);
    check_eq("t5.headE", 64'(inst_ID_o), 64'(32'hEEEE0005));

    // 6. overflow and rdy freeze
    step("t6.fill", 1, 32'hFFFF0006, 32'h20, 1, 0, 1);
    step("t6.ovf", 1, 32'h99990007, 32'h24, 1, 0, 1);
    check_eq("t6.ovf_set", 64'(ovf_err_o), 64'(1));
    check_eq("t6.headE", 64'(inst_ID_o), 64'(32'hEEEE0005));
    step("t6.frz_push", 1, 32'h77770008, 32'h28, 0, 0, 0);
    step("t6.frz_flush", 1, 32'h77770009, 32'h2C, 0, 1, 0);
    check_eq("t6.frz_full", 64'(full_IF_o), 64'(1));
    step("t6.flush_keeps_ovf", 0, 32'h0, 32'h0, 0, 1, 1);
    check_eq("t6.ovf_sticky", 64'(ovf_err_o), 64'(1));

    // random phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd.reset");
      end else begin
        step("rnd",
             logic'($urandom_range(0, 99) < 60),
             $urandom, $urandom,
             logic'($urandom_range(0, 99) < 40),
             logic'($urandom_range(0, 99) < 5),
             logic'($urandom_range(0, 99) < 90));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
